id_ex_elastic_buffer: RTL and testbench
=======================================

Name: id_ex_elastic_buffer

Overview:
Parametrised elastic pipeline buffer between decode_stage and execute_stage. It replaces the direct decode-to-execute wiring with a DEPTH-entry FIFO that uses a valid/ready handshake and flush. Each entry carries one decoded instruction (rd id, two operands, immediate, pc, illegal flag, control word). It lets the decode side run ahead of execute stalls and supports a branch-mispredict flush.

Parameters:
XLEN, 32, operand/immediate/pc width
REG_ID_W, 5, destination register id width
CTRL_W, 16, packed control_signals width
DEPTH, 4, entries; power of two, >=2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous reset, active-high
flush  in  1  discard all entries (mispredict/exception)
in_valid  in  1  producer has an entry
in_ready  out  1  buffer accepts an entry this cycle
in_rd_id  in  REG_ID_W  destination register
in_data1  in  XLEN  rs1 read data
in_data2  in  XLEN  rs2 read data
in_imm  in  XLEN  immediate
in_pc  in  XLEN  instruction pc
in_illegal  in  1  instruction_illegal flag
in_ctrl  in  CTRL_W  control word
out_valid  out  1  head entry presented
out_ready  in  1  execute consumes head
out_rd_id, out_data1, out_data2, out_imm, out_pc, out_illegal, out_ctrl  out  same widths as inputs  head entry fields
count  out  CNT_W  current occupancy
high_water  out  CNT_W  max occupancy since reset/clear
hw_clear  in  1  reset high_water to current count

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset. All state is updated on the rising edge of clk.
- Reset: count=0, wr_ptr=rd_ptr=0, high_water=0, storage contents don't-care. After reset: out_valid=0, all out_* fields=0, in_ready=1.
- in_ready = (count != DEPTH). It is independent of out_ready: a full buffer refuses a push even if a pop occurs in the same cycle.
- push = in_valid & in_ready & ~flush. Writes all fields to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- pop = out_valid & out_ready & ~flush. rd_ptr increments modulo DEPTH.
- count next value: +1 on push only, -1 on pop only, unchanged on push & pop.
- Latency: an entry pushed in cycle t is presented at the output no earlier than t+1 (registered path).
- out_valid = (count != 0) & ~flush. When out_valid=0, all out_* fields are driven to 0, never stale data.
- out_* fields are held stable while out_valid=1 and out_ready=0.
- Flush (priority over push/pop):
  - In the flush cycle, in_ready and out_valid are forced to 0.
  - Next edge: count=0 and wr_ptr=rd_ptr=0.
  - An in_valid in the same cycle is dropped and not held over.
- reset has priority over flush.
- high_water: each cycle takes max(high_water, next count).
  - hw_clear loads next count instead.
  - hw_clear and a count change in the same cycle: the post-update count is loaded.
- in_illegal is stored and forwarded unchanged; the buffer takes no action on it.
- Pointer wrap: DEPTH is a power of two, so pointers are log2(DEPTH) bits and wrap naturally. Full/empty is distinguished only by count.
- Assertion (simulation only): push never occurs when count==DEPTH; pop never occurs when count==0.

Optional Feature:
ID_EX_BYPASS_EN.
- Defined: when count==0, in_valid=1 and flush=0:
  - out_valid=1 and out_* = in_* combinationally (zero latency).
  - If out_ready=1 in that cycle, the entry passes through without being written; count stays 0.
  - If out_ready=0, the entry is written normally and is presented from storage the next cycle.
  - in_ready rule is unchanged.
- Undefined: strictly registered path, minimum 1-cycle latency, as in Behaviour.

Test Plan:
- Reset then idle: hold reset 3 cycles -> out_valid=0, count=0, in_ready=1, high_water=0, out_pc=0.
- Fill with DEPTH=4, out_ready=0, push pc 0x100,0x104,0x108,0x10C -> count=4, in_ready=0. A 5th push of pc 0x110 is refused. Then set out_ready=1 -> outputs pc 0x100,0x104,0x108,0x10C in order; count returns to 0; high_water=4.
- Simultaneous push/pop at count=2 for 6 cycles -> count stays 2; pointers wrap past index 3; order preserved; data1 = pc+1 checked per entry.
- Flush at count=3 with in_valid=1 (pc 0x200) -> in the flush cycle out_valid=0; next cycle count=0 and out_valid=0; pc 0x200 never appears at the output.
- Backpressure stability: out_ready=0 for 5 cycles with head imm=0xFFFF_F800, ctrl=0x00A5, illegal=1 -> all out_* fields unchanged every cycle. The head pops on the first out_ready=1.
- ID_EX_BYPASS_EN: empty buffer, in_valid=1, out_ready=1, pc 0x300 -> out_valid=1 and out_pc=0x300 in the same cycle, count stays 0. Without the macro, pc 0x300 appears one cycle later.

Source files
------------

// File: rtl/id_ex_elastic_buffer.sv
// id_ex_elastic_buffer: DEPTH-entry valid/ready FIFO between decode and
// execute, with flush and an occupancy high-water mark.
// Optional macro ID_EX_BYPASS_EN: zero-latency pass-through when the
// buffer is empty (default build keeps a strictly registered path).
module id_ex_elastic_buffer #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5,
  parameter int CTRL_W   = 16,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_ID_W-1:0] in_rd_id,
  input  logic [XLEN-1:0]     in_data1,
  input  logic [XLEN-1:0]     in_data2,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                in_illegal,
  input  logic [CTRL_W-1:0]   in_ctrl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_ID_W-1:0] out_rd_id,
  output logic [XLEN-1:0]     out_data1,
  output logic [XLEN-1:0]     out_data2,
  output logic [XLEN-1:0]     out_imm,
  output logic [XLEN-1:0]     out_pc,
  output logic                out_illegal,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [CNT_W-1:0]    count,
  output logic [CNT_W-1:0]    high_water,
  input  logic                hw_clear
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = REG_ID_W + 4*XLEN + 1 + CTRL_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] in_ent, sel_ent, out_ent;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_nxt, hw_nxt;
  logic             full, empty, stor_valid, push, pop, byp, byp_take;

  assign in_ent = {in_rd_id, in_data1, in_data2, in_imm, in_pc, in_illegal, in_ctrl};
  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);

  // Full is judged on the current count only, so a pop in the same cycle
  // never frees a slot for a simultaneous push.
  assign in_ready   = ~full & ~flush;
  assign stor_valid = ~empty & ~flush;

`ifdef ID_EX_BYPASS_EN
  assign byp      = empty & in_valid & ~flush;
  assign byp_take = byp & out_ready;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
`endif

  // A bypassed entry that execute consumes immediately is never stored.
  assign push      = in_valid & in_ready & ~byp_take;
  assign pop       = stor_valid & out_ready;
  assign out_valid = stor_valid | byp;

  assign sel_ent = byp ? in_ent : mem[rd_ptr];
  // Idle outputs read as zero rather than stale storage.
  assign out_ent = out_valid ? sel_ent : '0;
  assign {out_rd_id, out_data1, out_data2, out_imm, out_pc, out_illegal, out_ctrl} = out_ent;

  // Next occupancy and high-water value; flush empties the buffer outright.
  always_comb begin
    count_nxt = count;
    if (flush)              count_nxt = '0;
    else if (push && !pop)  count_nxt = count + CNT_W'(1);
    else if (pop && !push)  count_nxt = count - CNT_W'(1);
    if (hw_clear)                  hw_nxt = count_nxt;
    else if (count_nxt > high_water) hw_nxt = count_nxt;
    else                           hw_nxt = high_water;
  end

  // Pointer, occupancy and high-water state; reset outranks flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      high_water <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count      <= count_nxt;
      high_water <= hw_nxt;
    end
  end

  // Entry storage; contents need no reset since validity lives in count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

`ifndef SYNTHESIS
  // Overflow/underflow guards on the handshake decode.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full))  else $error("push into full buffer");
      assert (!(pop && empty))  else $error("pop from empty buffer");
    end
  end
`endif
endmodule

// File: tb/tb_id_ex_elastic_buffer.sv
// Bench for id_ex_elastic_buffer: directed vector table, hand sequences and
// randomized traffic checked against a queue-based reference model.
module tb_id_ex_elastic_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef ID_EX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, in_ready, in_illegal, out_valid, out_ready;
  logic        out_illegal, hw_clear;
  logic [4:0]  in_rd_id, out_rd_id;
  logic [31:0] in_data1, in_data2, in_imm, in_pc;
  logic [31:0] out_data1, out_data2, out_imm, out_pc;
  logic [15:0] in_ctrl, out_ctrl;
  logic [CNT_W-1:0] count, high_water;

  id_ex_elastic_buffer #(.XLEN(32), .REG_ID_W(5), .CTRL_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd_id(in_rd_id),
    .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm), .in_pc(in_pc),
    .in_illegal(in_illegal), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_id(out_rd_id),
    .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm), .out_pc(out_pc),
    .out_illegal(out_illegal), .out_ctrl(out_ctrl),
    .count(count), .high_water(high_water), .hw_clear(hw_clear)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d1, d2, imm, pc;
    logic        ill;
    logic [15:0] ctrl;
  } ent_t;

  typedef struct {
    bit rst, fl, iv, ordy, hwc, chk;
    logic [31:0] pc;
    bit ov, irdy;
    logic [31:0] opc;
    int cnt, hw;
  } vec_t;

  ent_t q[$];
  int   hw_m;
  bit   model_ok = 1'b0;
  int   checks = 0, errors = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t cur_in();
    return '{rd: in_rd_id, d1: in_data1, d2: in_data2, imm: in_imm, pc: in_pc,
             ill: in_illegal, ctrl: in_ctrl};
  endfunction

  // Directed entries derive every field from pc so order is easy to spot.
  task automatic drive(input bit iv, input logic [31:0] pc);
    in_valid   = iv;
    in_pc      = pc;
    in_data1   = pc + 32'd1;
    in_data2   = ~pc;
    in_imm     = pc << 2;
    in_rd_id   = pc[6:2];
    in_ctrl    = pc[15:0] ^ 16'h5a5a;
    in_illegal = pc[2];
  endtask

  task automatic check_model();
    ent_t e;
    bit ev, er;
    e  = '0;
    ev = 1'b0;
    er = !flush && (q.size() != DEPTH);
    if (!flush) begin
      if (q.size() > 0) begin ev = 1'b1; e = q[0]; end
      else if (BYP && in_valid) begin ev = 1'b1; e = cur_in(); end
    end
    chk("in_ready", {63'd0, in_ready}, {63'd0, er});
    chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
    chk("count", 64'(count), 64'(q.size()));
    chk("high_water", 64'(high_water), 64'(hw_m));
    chk("out_pc", 64'(out_pc), 64'(e.pc));
    chk("out_data1", 64'(out_data1), 64'(e.d1));
    chk("out_data2", 64'(out_data2), 64'(e.d2));
    chk("out_imm", 64'(out_imm), 64'(e.imm));
    chk("out_rd_id", 64'(out_rd_id), 64'(e.rd));
    chk("out_illegal", {63'd0, out_illegal}, {63'd0, e.ill});
    chk("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
  endtask

  task automatic update_model();
    int  n0;
    bit  take, do_pop, do_push;
    if (reset) begin
      q.delete();
      hw_m = 0;
      model_ok = 1'b1;
    end else if (flush) begin
      q.delete();
      if (hw_clear) hw_m = 0;
    end else begin
      n0      = q.size();
      take    = BYP && n0 == 0 && in_valid && out_ready;
      do_pop  = n0 > 0 && out_ready;
      do_push = in_valid && n0 != DEPTH && !take;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(cur_in());
      if (hw_clear || q.size() > hw_m) hw_m = q.size();
    end
  endtask

  // Sample mid-cycle at the falling edge, then advance model at the rising edge.
  task automatic mid();
    @(negedge clk);
    if (model_ok) check_model();
  endtask

  task automatic fin();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic add(input bit rst, fl, iv, ordy, hwc, chk_en, input logic [31:0] pc,
                     input bit ov, input logic [31:0] opc, input int cnt, input bit irdy, input int hw);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.hwc = hwc; v.chk = chk_en;
    v.pc = pc; v.ov = ov; v.opc = opc; v.cnt = cnt; v.irdy = irdy; v.hw = hw;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; hw_clear = 1'b0;
    drive(1'b0, 32'h0);

    //   rst fl iv or hc ck  pc           ov   opc                    cnt irdy hw
    add(1, 0, 0, 0, 0, 0, 32'h0,   0, 32'h0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 32'h0,   0, 32'h0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 32'h0,   0, 32'h0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 32'h0,   0, 32'h0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 1, 32'h100, BYP, BYP ? 32'h100 : 32'h0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 1, 32'h104, 1, 32'h100, 1, 1, 1);
    add(0, 0, 1, 0, 0, 1, 32'h108, 1, 32'h100, 2, 1, 2);
    add(0, 0, 1, 0, 0, 1, 32'h10C, 1, 32'h100, 3, 1, 3);
    add(0, 0, 1, 0, 0, 1, 32'h110, 1, 32'h100, 4, 0, 4);
    add(0, 0, 1, 1, 0, 1, 32'h110, 1, 32'h100, 4, 0, 4);
    add(0, 0, 0, 1, 0, 1, 32'h0,   1, 32'h104, 3, 1, 4);
    add(0, 0, 0, 1, 0, 1, 32'h0,   1, 32'h108, 2, 1, 4);
    add(0, 0, 0, 1, 0, 1, 32'h0,   1, 32'h10C, 1, 1, 4);
    add(0, 0, 0, 1, 0, 1, 32'h0,   0, 32'h0,   0, 1, 4);
    add(0, 0, 1, 0, 0, 1, 32'h1F0, BYP, BYP ? 32'h1F0 : 32'h0, 0, 1, 4);
    add(0, 0, 1, 0, 0, 1, 32'h1F4, 1, 32'h1F0, 1, 1, 4);
    add(0, 0, 1, 0, 0, 1, 32'h1F8, 1, 32'h1F0, 2, 1, 4);
    add(0, 1, 1, 0, 0, 1, 32'h200, 0, 32'h0,   3, 0, 4);
    add(0, 0, 0, 0, 0, 1, 32'h0,   0, 32'h0,   0, 1, 4);
    add(0, 0, 0, 0, 1, 1, 32'h0,   0, 32'h0,   0, 1, 4);
    add(0, 0, 0, 0, 0, 1, 32'h0,   0, 32'h0,   0, 1, 0);
    add(0, 0, 1, 1, 0, 1, 32'h300, BYP, BYP ? 32'h300 : 32'h0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1, 32'h0,   !BYP, BYP ? 32'h0 : 32'h300, BYP ? 0 : 1, 1, BYP ? 0 : 1);
    add(0, 0, 0, 1, 0, 1, 32'h0,   0, 32'h0,   0, 1, BYP ? 0 : 1);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; flush = vecs[i].fl; out_ready = vecs[i].ordy;
      hw_clear = vecs[i].hwc;
      drive(vecs[i].iv, vecs[i].pc);
      mid();
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].ov});
        chk($sformatf("vec%0d out_pc", i), 64'(out_pc), 64'(vecs[i].opc));
        chk($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].cnt));
        chk($sformatf("vec%0d in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].irdy});
        chk($sformatf("vec%0d high_water", i), 64'(high_water), 64'(vecs[i].hw));
      end
      fin();
    end
    reset = 1'b0; flush = 1'b0; hw_clear = 1'b0;

    // Steady push+pop at count 2; pointers wrap twice over 8 pushes.
    out_ready = 1'b0;
    drive(1'b1, 32'h400); mid(); fin();
    drive(1'b1, 32'h404); mid(); fin();
    for (int k = 0; k < 6; k++) begin
      out_ready = 1'b1;
      drive(1'b1, 32'h408 + 32'(4*k));
      mid();
      chk("pp count", 64'(count), 64'd2);
      chk("pp out_pc", 64'(out_pc), 64'(32'h400 + 32'(4*k)));
      chk("pp out_data1", 64'(out_data1), 64'(32'h401 + 32'(4*k)));
      fin();
    end
    drive(1'b0, 32'h0);
    mid(); fin();
    mid(); fin();

    // Backpressure: head must hold steady until execute accepts it.
    out_ready = 1'b0;
    drive(1'b1, 32'h500);
    in_imm = 32'hFFFF_F800; in_ctrl = 16'h00A5; in_illegal = 1'b1;
    mid(); fin();
    drive(1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("bp out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp out_imm", 64'(out_imm), 64'hFFFF_F800);
      chk("bp out_ctrl", 64'(out_ctrl), 64'h00A5);
      chk("bp out_illegal", {63'd0, out_illegal}, 64'd1);
      chk("bp out_pc", 64'(out_pc), 64'h500);
      fin();
    end
    out_ready = 1'b1;
    mid(); chk("bp pop valid", {63'd0, out_valid}, 64'd1); fin();
    mid(); chk("bp drained", 64'(count), 64'd0); fin();

    // Randomized traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      hw_clear   = ($urandom_range(0, 15) == 0);
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      in_rd_id   = 5'($urandom);
      in_data1   = $urandom;
      in_data2   = $urandom;
      in_imm     = $urandom;
      in_pc      = $urandom;
      in_illegal = 1'($urandom);
      in_ctrl    = 16'($urandom);
      mid(); fin();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
